// File: rtl/sha_1_pkg.sv
// sha_1_pkg: shared types, constants and the tail-word padding helper for the SHA-1 padder.
package sha_1_pkg;
   typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;
   localparam int BLOCK_WORDS = 16;
   localparam logic [31:0] PAD_WORD = 32'h8000_0000;
   function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] nb);
      return nb == 3'd0 ? PAD_WORD :
             nb == 3'd1 ? {w[31:24], 24'h80_0000} :
             nb == 3'd2 ? {w[31:16], 16'h8000} :
             nb == 3'd3 ? {w[31:8], 8'h80} : w;
   endfunction
endpackage

// File: rtl/sha_1_padder.sv
// sha_1_padder: packs a big-endian word stream into padded 512-bit SHA-1 blocks,
// appending 0x80, zero fill and the 64-bit bit length, with an extra block when it does not fit.
module sha_1_padder
   import sha_1_pkg::*;
#(
   parameter int LEN_WIDTH = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] in_word,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic [2:0]  in_bytes,
   output logic        in_ready,
   output logic [31:0] blk_data [BLOCK_WORDS],
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        blk_first,
   output logic        blk_last
);
   state_t               state;
   logic [3:0]           idx;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] len_add;
   logic                 pend;
   logic                 pend_pad;
   logic [2:0]           nb;
   logic [4:0]           p;
   logic [63:0]          l_fill;
   logic [63:0]          l_ext;
   logic [31:0]          fill_data [BLOCK_WORDS];
   logic [31:0]          ext_data [BLOCK_WORDS];
   assign in_ready = reset_n && state == FILL;
   always_comb begin
      nb = in_bytes > 3'd4 ? 3'd4 : in_bytes;
      len_add = len + (in_last ? LEN_WIDTH'({nb, 3'b000}) : LEN_WIDTH'(32));
      l_fill = 64'(len_add);
      l_ext = 64'(len);
      p = {1'b0, idx} + {4'b0000, nb == 3'd4};
      for (int j = 0; j < BLOCK_WORDS; j++) begin
         fill_data[j] = 5'(j) < {1'b0, idx} ? blk_data[j] :
                        5'(j) == {1'b0, idx} ? (in_last ? pad_word(in_word, nb) : in_word) :
                        (in_last && 5'(j) == p) ? PAD_WORD : 32'h0;
         ext_data[j] = 32'h0;
      end
      // the length only lands here when the 0x80 word left room for it
      if (in_last && p <= 5'd13) begin
         fill_data[14] = l_fill[63:32];
         fill_data[15] = l_fill[31:0];
      end
      ext_data[0] = pend_pad ? PAD_WORD : 32'h0;
      ext_data[14] = l_ext[63:32];
      ext_data[15] = l_ext[31:0];
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= FILL;
         idx <= 4'd0;
         len <= '0;
         blk_first <= 1'b1;
         blk_valid <= 1'b0;
         blk_last <= 1'b0;
         pend <= 1'b0;
         pend_pad <= 1'b0;
         for (int j = 0; j < BLOCK_WORDS; j++) blk_data[j] <= 32'h0;
      end else begin
         case (state)
            FILL: if (in_valid) begin
               blk_data <= fill_data;
               len <= len_add;
               if (in_last) begin
                  state <= EMIT;
                  blk_valid <= 1'b1;
                  blk_last <= p <= 5'd13;
                  pend <= p > 5'd13;
                  pend_pad <= p == 5'd16;
               end else if (idx == 4'd15) begin
                  state <= EMIT;
                  blk_valid <= 1'b1;
                  blk_last <= 1'b0;
               end else idx <= idx + 4'd1;
            end
            EMIT: if (blk_ready) begin
               blk_valid <= 1'b0;
               blk_first <= blk_last;
               if (blk_last) len <= '0;
               state <= pend ? EXTRA : FILL;
               idx <= 4'd0;
            end
            EXTRA: begin
               blk_data <= ext_data;
               blk_last <= 1'b1;
               blk_valid <= 1'b1;
               pend <= 1'b0;
               state <= EMIT;
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_sha_1_padder.sv
// tb_sha_1_padder: directed vectors with hand-computed padded blocks for sha_1_padder.
module tb_sha_1_padder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] in_word = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [2:0]  in_bytes = 3'd0;
   logic        in_ready;
   logic [31:0] blk_data [16];
   logic        blk_valid;
   logic        blk_ready = 1'b0;
   logic        blk_first;
   logic        blk_last;
   logic [31:0] got [16];
   logic [31:0] exp_w [16];
   logic        got_first, got_last;
   logic [31:0] hold0;
   int          n_cmp = 0;
   int          n_bad = 0;

   sha_1_padder #(.LEN_WIDTH(64)) dut (
      .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_valid(in_valid),
      .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
      .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_first(blk_first), .blk_last(blk_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] d(input int i);
      return {8'(i), 8'hA5, 8'(i), 8'h5A};
   endfunction

   task automatic put(input logic [31:0] w, input logic last, input logic [2:0] nb);
      int n = 0;
      @(negedge clk);
      in_word = w;
      in_last = last;
      in_bytes = nb;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic get_blk();
      int n = 0;
      @(negedge clk);
      while (!blk_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!blk_valid) check("blk_timeout", 32'(blk_valid), 32'd1);
      got = blk_data;
      got_first = blk_first;
      got_last = blk_last;
      blk_ready = 1'b1;
      @(posedge clk);
      #1 blk_ready = 1'b0;
   endtask

   task automatic cmp_blk(input string tag, input logic f, input logic l);
      for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), got[i], exp_w[i]);
      check({tag, "_first"}, 32'(got_first), 32'(f));
      check({tag, "_last"}, 32'(got_last), 32'(l));
   endtask

   task automatic abc_case(input string tag);
      put(32'h6162_6300, 1'b1, 3'd3);
      check({tag, "_lat"}, 32'(blk_valid), 32'd1);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[0] = 32'h6162_6380;
      exp_w[15] = 32'h18;
      cmp_blk(tag, 1'b1, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_blk_valid", 32'(blk_valid), 32'd0);
      check("rst_blk_last", 32'(blk_last), 32'd0);
      check("rst_blk_first", 32'(blk_first), 32'd1);
      check("rst_word0", blk_data[0], 32'h0);
      reset_n = 1'b1;
      #1 check("rst_rel_ready", 32'(in_ready), 32'd1);

      abc_case("abc");

      put(32'h0, 1'b1, 3'd0);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[0] = 32'h8000_0000;
      cmp_blk("empty", 1'b1, 1'b1);

      for (int i = 0; i < 13; i++) put(d(i), 1'b0, 3'd0);
      put(d(13), 1'b1, 3'd4);
      get_blk();
      exp_w = '{default: 32'h0};
      for (int i = 0; i < 14; i++) exp_w[i] = d(i);
      exp_w[14] = 32'h8000_0000;
      cmp_blk("b56a", 1'b1, 1'b0);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[15] = 32'h1C0;
      cmp_blk("b56b", 1'b0, 1'b1);

      for (int i = 0; i < 15; i++) put(d(i), 1'b0, 3'd0);
      put(d(15), 1'b1, 3'd4);
      get_blk();
      for (int i = 0; i < 16; i++) exp_w[i] = d(i);
      cmp_blk("b64a", 1'b1, 1'b0);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[0] = 32'h8000_0000;
      exp_w[15] = 32'h200;
      cmp_blk("b64b", 1'b0, 1'b1);

      for (int i = 0; i < 16; i++) put(d(i), 1'b0, 3'd0);
      get_blk();
      for (int i = 0; i < 16; i++) exp_w[i] = d(i);
      cmp_blk("t64a", 1'b1, 1'b0);
      put(32'h0, 1'b1, 3'd0);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[0] = 32'h8000_0000;
      exp_w[15] = 32'h200;
      cmp_blk("t64b", 1'b0, 1'b1);

      for (int i = 0; i < 14; i++) put(d(i), 1'b0, 3'd0);
      put(32'hDEAD_BEEF, 1'b1, 3'd2);
      get_blk();
      exp_w = '{default: 32'h0};
      for (int i = 0; i < 14; i++) exp_w[i] = d(i);
      exp_w[14] = 32'hDEAD_8000;
      cmp_blk("p14a", 1'b1, 1'b0);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[15] = 32'h1D0;
      cmp_blk("p14b", 1'b0, 1'b1);

      put(d(0), 1'b0, 3'd0);
      put(d(1), 1'b1, 3'd7);
      get_blk();
      exp_w = '{default: 32'h0};
      exp_w[0] = d(0);
      exp_w[1] = d(1);
      exp_w[2] = 32'h8000_0000;
      exp_w[15] = 32'h40;
      cmp_blk("nb7", 1'b1, 1'b1);

      put(32'h6162_6300, 1'b1, 3'd3);
      @(negedge clk);
      hold0 = blk_data[0];
      check("stall_w0_ref", hold0, 32'h6162_6380);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall_valid%0d", c), 32'(blk_valid), 32'd1);
         check($sformatf("stall_ready%0d", c), 32'(in_ready), 32'd0);
         check($sformatf("stall_w0_%0d", c), blk_data[0], hold0);
         check($sformatf("stall_w15_%0d", c), blk_data[15], 32'h18);
         @(negedge clk);
      end
      blk_ready = 1'b1;
      @(posedge clk);
      #1 blk_ready = 1'b0;
      check("stall_post_ready", 32'(in_ready), 32'd1);
      check("stall_post_valid", 32'(blk_valid), 32'd0);

      for (int i = 0; i < 7; i++) put(d(i), 1'b0, 3'd0);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_valid", 32'(blk_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      abc_case("abc_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sha_1_padder.md
SHA_1_PADDER -- requirements
Module: sha_1_padder

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 64, the width of the message bit-length counter; legal range 32..64; upper bits of the 64-bit length field are zero-filled.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_word, input, 32, message word, big-endian, valid bytes left-justified.
REQ-005 SHALL have port in_valid, input, 1, in_word/in_last/in_bytes are valid.
REQ-006 SHALL have port in_last, input, 1, the current word is the final word of the message.
REQ-007 SHALL have port in_bytes, input, 3, count of valid bytes (0..4), sampled only with in_last; 0 is legal only for an empty tail word.
REQ-008 SHALL have port in_ready, output, 1, the block accepts a word this cycle.
REQ-009 SHALL have port blk_data, output, 16 unpacked x 32, padded 512-bit block; index 0 is the first word.
REQ-010 SHALL have port blk_valid, output, 1, blk_data/blk_first/blk_last are valid.
REQ-011 SHALL have port blk_ready, input, 1, downstream hash stage accepts the block.
REQ-012 SHALL have port blk_first, output, 1, first block of a message (hash state re-initialises).
REQ-013 SHALL have port blk_last, output, 1, final block of a message (digest is valid after it).

Function
REQ-014 SHALL implement states FILL, EMIT, EXTRA; FILL accepts words, EMIT presents a block, and EXTRA builds a padding-only block.
REQ-015 SHALL assert in_ready only in FILL; a word transfers on in_valid & in_ready, at most one per cycle, into word index idx (0..15).
REQ-016 SHALL, on a non-last transfer, add 32 to the bit length; on a last transfer, add 8*in_bytes, with values 5..7 treated as 4.
REQ-017 SHALL, on a last transfer, zero the invalid bytes and insert byte 0x80 directly after the last valid byte; if in_bytes=4, the 0x80 is placed in word idx+1; p denotes the index of the word holding 0x80.
REQ-018 SHALL zero all words between p and 13.
REQ-019 SHALL, if p<=13, place the length in words 14 (upper) and 15 (lower), set blk_last=1, and go to EMIT.
REQ-020 SHALL, if p is 14 or 15, emit the current block with blk_last=0 and then build an EXTRA block with words 0..13 zero and the length in words 14..15.
REQ-021 SHALL, if p=16, emit the current block with blk_last=0 and then build an EXTRA block with word0=32'h8000_0000, words 1..13 zero, and the length in words 14..15.
REQ-022 SHALL, on a non-last transfer at idx=15, go to EMIT with blk_last=0.
REQ-023 SHALL assert blk_valid in the cycle after the transfer that completes a block (latency 1).
REQ-024 SHALL hold blk_data, blk_first and blk_last stable while blk_valid=1 and blk_ready=0.
REQ-025 SHALL, on blk_valid & blk_ready, go to EXTRA if an extra block is pending, otherwise to FILL with idx=0; in_ready rises the next cycle.
REQ-026 SHALL, after a blk_last block is handshaken, clear the length and set blk_first for the next message's first block.
REQ-027 SHALL build an EXTRA block in one cycle and present it with blk_valid on the following cycle, with blk_first=0 and blk_last=1.
REQ-028 SHALL let the bit length wrap modulo 2^LEN_WIDTH with no error indication.

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, set state=FILL, idx=0, length=0, blk_first=1, blk_valid=0, blk_last=0, blk_data all zero, and no pending extra block.
REQ-030 SHALL hold in_ready=0 during reset; in_ready=1 on the first cycle after reset_n returns to 1.
REQ-031 SHALL, when reset occurs mid-message or mid-handshake, discard the partial message with no block emitted.

Structure
REQ-032 SHALL define in package sha_1_pkg: the FILL/EMIT/EXTRA state enum, BLOCK_WORDS=16, PAD_WORD=32'h8000_0000, and a byte-mask/0x80-insert function.
REQ-033 SHALL be one module with no sub-module; the target is 120-400 RTL lines.

Verification
REQ-034 SHALL pass: "abc" as one word 0x61626300 with in_last=1, in_bytes=3 -> one block, word0=0x61626380, words1..14=0, word15=0x18, blk_first=blk_last=1.
REQ-035 SHALL pass: empty message, in_last=1, in_bytes=0 -> word0=0x80000000, all other words 0, blk_first=blk_last=1.
REQ-036 SHALL pass: 56-byte message (14 words, last in_bytes=4) -> block1 with word14=0x80000000, word15=0 and blk_last=0; then block2 with words 0..14=0, word15=0x1C0 and blk_last=1.
REQ-037 SHALL pass: 64-byte message -> block1 holds the data with blk_last=0; block2 has word0=0x80000000 and word15=0x200.
REQ-038 SHALL pass: blk_ready held low 5 cycles -> blk_data stable and in_ready=0 throughout; handshake on cycle 6 -> in_ready=1 on cycle 7.
REQ-039 SHALL pass: reset_n low after 7 words -> the next message "abc" produces the REQ-034 block with blk_first=1.
